// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding and
// default release timing.
package rst_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_MEM  = 2'd1,
    ST_CORE = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam int unsigned DEF_HOLD_CYC = 16;
  localparam int unsigned DEF_GAP_CYC  = 4;
  localparam int unsigned DEF_CNT_W    = 8;

endpackage

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds all CPU domains in reset, then releases
// memory, core and fetch in order; a software request replays the sequence.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HOLD | all domains in reset, counting HOLD_CYC
// ST_MEM  | memory released, counting GAP_CYC before core release
// ST_CORE | memory+core released, counting GAP_CYC before fetch release
// ST_RUN  | all released, watching for a software reset request
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic soft_rst_req,
  output logic mem_rst_n,
  output logic core_rst_n,
  output logic fetch_rst_n,
  output logic rst_busy,
  output logic soft_rst_ack
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_limit;
  logic             w_tc;
  logic             r_mem, r_core, r_fetch, r_busy, r_ack;
  logic             w_mem, w_core, w_fetch, w_busy, w_ack;

  assign w_limit = (r_state == ST_HOLD) ? HOLD_LIM : GAP_LIM;
  assign w_tc    = (r_cnt == w_limit);

  // Output next-values are derived per state so every release is a flop edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_mem       = 1'b0;
    w_core      = 1'b0;
    w_fetch     = 1'b0;
    w_busy      = 1'b1;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_HOLD: begin
        w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_ONE;
        w_mem     = w_tc;
        if (w_tc) w_state_nxt = ST_MEM;
      end
      ST_MEM: begin
        w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_ONE;
        w_mem     = 1'b1;
        w_core    = w_tc;
        if (w_tc) w_state_nxt = ST_CORE;
      end
      ST_CORE: begin
        w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_ONE;
        w_mem     = 1'b1;
        w_core    = 1'b1;
        w_fetch   = w_tc;
        w_busy    = ~w_tc;
        if (w_tc) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_mem   = ~soft_rst_req;
        w_core  = ~soft_rst_req;
        w_fetch = ~soft_rst_req;
        w_busy  = soft_rst_req;
        w_ack   = soft_rst_req;
        if (soft_rst_req) w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_mem   <= 1'b0;
      r_core  <= 1'b0;
      r_fetch <= 1'b0;
      r_busy  <= 1'b1;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mem   <= w_mem;
      r_core  <= w_core;
      r_fetch <= w_fetch;
      r_busy  <= w_busy;
      r_ack   <= w_ack;
    end
  end

  assign mem_rst_n    = r_mem;
  assign core_rst_n   = r_core;
  assign fetch_rst_n  = r_fetch;
  assign rst_busy     = r_busy;
  assign soft_rst_ack = r_ack;

endmodule
